hit_map_framer: RTL and testbench

- Upstream stage of the cluster counter: turns a backpressured stream of detector hit rows into the continuous framed map stream that the counter consumes.
- Each frame is emitted as start marker, data rows, stop marker, then idle zero rows.
- Buffers whole frames so data rows leave back-to-back with no bubbles; bubbles would split clusters.
- Guards against rows that alias the marker patterns.

---
 rtl/hit_map_framer.sv | 243 ++++++++++++++++++++++++
 tb/tb_hit_map_framer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_map_framer.sv
// hit_map_framer: buffers backpressured hit-row frames and replays them as
// START, data rows, STOP and idle zero words with no bubbles inside a frame.

module hit_map_framer #(
  parameter int MAPSIZE  = 38,
  parameter int MAX_ROWS = 16,
  parameter int GAP      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MAPSIZE:0] row_in,
  input  logic             row_valid,
  input  logic             row_sof,
  input  logic             row_eof,
  output logic             row_ready,
  input  logic             err_clr,
  output logic [MAPSIZE:0] map_out,
  output logic             frame_active,
  output logic [15:0]      frame_cnt,
  output logic             alias_err,
  output logic             trunc_err,
  output logic             proto_err
);

  localparam int W  = MAPSIZE + 1;
  localparam int AW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
  localparam int CW = $clog2(MAX_ROWS + 1) + 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  function automatic logic [W-1:0] mk_start();
    logic [W-1:0] p;
    for (int i = 0; i < W; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [W-1:0] START_W = mk_start();
  localparam logic [W-1:0] STOP_W  = ~START_W;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_ROWS - 1)) ? '0 : p + 1'b1;
  endfunction

  typedef struct packed {
    logic         sof;
    logic         last;
    logic [W-1:0] row;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  entry_t mem [MAX_ROWS];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] cmpl_q, cmpl_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          rdy_q, rdy_d;
  logic          open_q, open_d;
  logic          drop_q, drop_d;
  state_t        state_q, state_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [W-1:0]  map_q, map_d;
  logic          act_q, act_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          alias_q, alias_d;
  logic          trunc_q, trunc_d;
  logic          proto_q, proto_d;

  logic          acc;
  logic          aliased;
  logic          push;
  logic          pop;
  logic          dec;
  logic [1:0]    inc;
  logic          alias_ev;
  logic          trunc_ev;
  logic          proto_ev;
  entry_t        wr_ent;

  assign acc     = row_valid && rdy_q;
  assign aliased = (row_in == START_W) || (row_in == STOP_W);
  assign rd_nxt  = ptr_inc(rd_ptr_q);

  // Frame assembly: decides what each accepted row becomes in the FIFO.
  always_comb begin
    push       = 1'b0;
    inc        = 2'd0;
    alias_ev   = 1'b0;
    trunc_ev   = 1'b0;
    proto_ev   = 1'b0;
    open_d     = open_q;
    drop_d     = drop_q;
    rcnt_d     = rcnt_q;
    wr_ent.sof  = row_sof;
    wr_ent.last = row_eof;
    wr_ent.row  = aliased ? '0 : row_in;
    if (acc) begin
      if (row_sof) begin
        push     = 1'b1;
        alias_ev = aliased;
        drop_d   = 1'b0;
        rcnt_d   = CW'(1);
        open_d   = !row_eof;
        if (open_q) inc = 2'd1;
        if (row_eof) inc = inc + 2'd1;
      end else if (drop_q) begin
        trunc_ev = 1'b1;
        if (row_eof) drop_d = 1'b0;
      end else if (!open_q) begin
        proto_ev = 1'b1;
      end else begin
        push     = 1'b1;
        alias_ev = aliased;
        rcnt_d   = rcnt_q + 1'b1;
        if (row_eof || rcnt_q == CW'(MAX_ROWS - 1)) begin
          wr_ent.last = 1'b1;
          open_d      = 1'b0;
          rcnt_d      = '0;
          inc         = 2'd1;
          drop_d      = !row_eof;
        end
      end
    end
  end

  // Read-side sequencer; every output is the registered word for this state.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    map_d   = map_q;
    act_d   = act_q;
    fcnt_d  = fcnt_q;
    pop     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        map_d = '0;
        act_d = 1'b0;
        if (cmpl_q != '0) begin
          state_d = S_START;
          dec     = 1'b1;
        end
      end
      S_START: begin
        map_d   = START_W;
        act_d   = 1'b1;
        state_d = S_DATA;
      end
      S_DATA: begin
        pop   = (count_q != '0);
        map_d = mem[rd_ptr_q].row;
        act_d = 1'b1;
        if (mem[rd_ptr_q].last ||
            (count_q > CW'(1) && mem[rd_nxt].sof))
          state_d = S_STOP;
      end
      S_STOP: begin
        map_d   = STOP_W;
        act_d   = 1'b1;
        fcnt_d  = fcnt_q + 16'd1;
        gcnt_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        map_d  = '0;
        act_d  = 1'b0;
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GW'(GAP - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    cmpl_d   = cmpl_q + CW'(inc) - CW'(dec);
    rdy_d    = (count_d < CW'(MAX_ROWS));
    alias_d  = (alias_q && !err_clr) || alias_ev;
    trunc_d  = (trunc_q && !err_clr) || trunc_ev;
    proto_d  = (proto_q && !err_clr) || proto_ev;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmpl_q   <= '0;
      rcnt_q   <= '0;
      rdy_q    <= 1'b0;
      open_q   <= 1'b0;
      drop_q   <= 1'b0;
      state_q  <= S_IDLE;
      gcnt_q   <= '0;
      map_q    <= '0;
      act_q    <= 1'b0;
      fcnt_q   <= '0;
      alias_q  <= 1'b0;
      trunc_q  <= 1'b0;
      proto_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmpl_q   <= cmpl_d;
      rcnt_q   <= rcnt_d;
      rdy_q    <= rdy_d;
      open_q   <= open_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      map_q    <= map_d;
      act_q    <= act_d;
      fcnt_q   <= fcnt_d;
      alias_q  <= alias_d;
      trunc_q  <= trunc_d;
      proto_q  <= proto_d;
    end
  end

  assign row_ready    = rdy_q;
  assign map_out      = map_q;
  assign frame_active = act_q;
  assign frame_cnt    = fcnt_q;
  assign alias_err    = alias_q;
  assign trunc_err    = trunc_q;
  assign proto_err    = proto_q;

endmodule

// File: tb/tb_hit_map_framer.sv
// Bench for hit_map_framer: frame-level reference model feeding a word
// scoreboard, with directed cases followed by randomized frames.

module tb_hit_map_framer;

  localparam int W  = 39;
  localparam int MR = 16;
  localparam int GP = 4;
  localparam logic [W-1:0] START = 39'h55_5555_5555;
  localparam logic [W-1:0] STOP  = 39'h2A_AAAA_AAAA;

  logic         clk;
  logic         reset;
  logic [W-1:0] row_in;
  logic         row_valid;
  logic         row_sof;
  logic         row_eof;
  logic         row_ready;
  logic         err_clr;
  logic [W-1:0] map_out;
  logic         frame_active;
  logic [15:0]  frame_cnt;
  logic         alias_err;
  logic         trunc_err;
  logic         proto_err;

  hit_map_framer #(.MAPSIZE(38), .MAX_ROWS(MR), .GAP(GP)) dut (
    .clk(clk),
    .reset(reset),
    .row_in(row_in),
    .row_valid(row_valid),
    .row_sof(row_sof),
    .row_eof(row_eof),
    .row_ready(row_ready),
    .err_clr(err_clr),
    .map_out(map_out),
    .frame_active(frame_active),
    .frame_cnt(frame_cnt),
    .alias_err(alias_err),
    .trunc_err(trunc_err),
    .proto_err(proto_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [W-1:0] expq[$];
  logic [W-1:0] cur[$];
  bit m_open, m_drop, m_alias, m_trunc, m_proto;
  int exp_fcnt;
  bit in_frame, have_stop, mon_en;
  int start_cyc, stop_cyc, act_len, last_len, last_gap, eof_cyc;
  logic [W-1:0] mon_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void close_frame();
    expq.push_back(START);
    foreach (cur[i]) expq.push_back(cur[i]);
    expq.push_back(STOP);
    cur.delete();
    m_open = 1'b0;
  endfunction

  // Frame-level model of what an accepted row contributes to the stream.
  function automatic void model_accept(logic [W-1:0] r, bit sof, bit eof);
    bit al;
    logic [W-1:0] v;
    al = (r == START) || (r == STOP);
    v  = al ? '0 : r;
    if (sof) begin
      if (m_open) close_frame();
      m_drop = 1'b0;
      m_open = 1'b1;
      cur.push_back(v);
      if (al) m_alias = 1'b1;
      if (eof) close_frame();
    end else if (m_drop) begin
      m_trunc = 1'b1;
      if (eof) m_drop = 1'b0;
    end else if (!m_open) begin
      m_proto = 1'b1;
    end else begin
      cur.push_back(v);
      if (al) m_alias = 1'b1;
      if (eof) close_frame();
      else if (cur.size() == MR) begin
        close_frame();
        m_drop = 1'b1;
      end
    end
  endfunction

  task automatic send(logic [W-1:0] r, bit sof, bit eof);
    bit done;
    done      = 1'b0;
    row_in    = r;
    row_sof   = sof;
    row_eof   = eof;
    row_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (row_ready) begin
        model_accept(r, sof, eof);
        if (eof) eof_cyc = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'(row_ready), 64'(1));
  endtask

  task automatic idle(int n);
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_eof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 3000 && (expq.size() != 0 || in_frame); k++)
      @(negedge clk);
    if (k == 3000) check("drain_timeout", 64'(expq.size()), 64'(0));
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_alias = 1'b0;
    m_trunc = 1'b0;
    m_proto = 1'b0;
  endtask

  task automatic check_flags(string tag);
    check({tag, "_alias"}, 64'(alias_err), 64'(m_alias));
    check({tag, "_trunc"}, 64'(trunc_err), 64'(m_trunc));
    check({tag, "_proto"}, 64'(proto_err), 64'(m_proto));
  endtask

  // Monitor: every active word is popped from the expectation queue.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (frame_active) begin
        if (expq.size() == 0) begin
          check("unexpected_active", 64'(frame_active), 64'(0));
        end else begin
          mon_w = expq.pop_front();
          check("map_word", 64'(map_out), 64'(mon_w));
          if (mon_w == START) begin
            if (have_stop) begin
              last_gap = cyc - stop_cyc;
              check("gap_min", 64'(last_gap >= GP + 2), 64'(1));
            end
            in_frame  = 1'b1;
            start_cyc = cyc;
            act_len   = 0;
          end
          act_len++;
          if (mon_w == STOP) begin
            in_frame = 1'b0;
            exp_fcnt++;
            check("frame_cnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
            stop_cyc  = cyc;
            have_stop = 1'b1;
            last_len  = act_len;
          end
        end
      end else begin
        check("bubble", 64'(frame_active), 64'(in_frame));
        check("idle_word", 64'(map_out), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n, len;
    bit no_eof;
    logic [W-1:0] r;
    reset     = 1'b1;
    row_in    = '0;
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_eof   = 1'b0;
    err_clr   = 1'b0;
    mon_en    = 1'b0;
    #2;
    check("rst_map", 64'(map_out), 64'(0));
    check("rst_active", 64'(frame_active), 64'(0));
    check("rst_fcnt", 64'(frame_cnt), 64'(0));
    check("rst_ready", 64'(row_ready), 64'(0));
    check_flags("rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
    check("ready_before_edge", 64'(row_ready), 64'(0));
    @(posedge clk);
    #1;
    check("ready_after_edge", 64'(row_ready), 64'(1));

    // three-row frame from idle
    send(39'h6, 1'b1, 1'b0);
    send(39'h60, 1'b0, 1'b0);
    send(39'h600, 1'b0, 1'b1);
    idle(1);
    drain();
    check("t1_latency", 64'(start_cyc - eof_cyc), 64'(2));
    check("t1_active_len", 64'(last_len), 64'(5));
    check("t1_fcnt", 64'(frame_cnt), 64'(1));

    // two back-to-back two-row frames
    send(39'h11, 1'b1, 1'b0);
    send(39'h22, 1'b0, 1'b1);
    send(39'h44, 1'b1, 1'b0);
    send(39'h88, 1'b0, 1'b1);
    idle(1);
    drain();
    check("t2_gap", 64'(last_gap), 64'(GP + 2));
    check("t2_fcnt", 64'(frame_cnt), 64'(3));

    // 20-row frame truncated to 16, then a clean frame
    for (int i = 0; i < 20; i++)
      send(W'(i + 1) << 1, i == 0, i == 19);
    send(39'h1000, 1'b1, 1'b0);
    send(39'h2000, 1'b0, 1'b1);
    idle(1);
    drain();
    check("t3_trunc", 64'(trunc_err), 64'(1));
    check("t3_fcnt", 64'(frame_cnt), 64'(5));
    check_flags("t3");

    // aliasing row, then error clear
    send(START, 1'b1, 1'b0);
    send(39'h1e, 1'b0, 1'b1);
    idle(1);
    drain();
    check("t4_alias", 64'(alias_err), 64'(1));
    clear_err();
    check_flags("t4_clr");

    // row without sof from idle
    send(39'h18, 1'b0, 1'b1);
    idle(1);
    drain();
    check("t5_proto", 64'(proto_err), 64'(1));
    check("t5_fcnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
    clear_err();

    // reset in the middle of a frame's data
    for (int i = 0; i < 10; i++)
      send(W'(i + 3) << 2, i == 0, i == 9);
    idle(1);
    for (n = 0; n < 100 && !in_frame; n++) begin
      @(negedge clk);
      #1;
    end
    check("t6_reached_frame", 64'(in_frame), 64'(1));
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_map", 64'(map_out), 64'(0));
    check("t6_async_active", 64'(frame_active), 64'(0));
    check("t6_async_fcnt", 64'(frame_cnt), 64'(0));
    expq.delete();
    cur.delete();
    m_open = 0; m_drop = 0; m_alias = 0; m_trunc = 0; m_proto = 0;
    exp_fcnt = 0; in_frame = 0; have_stop = 0;
    repeat (2) @(negedge clk);
    check("t6_ready_in_reset", 64'(row_ready), 64'(0));
    reset = 1'b0;
    mon_en = 1'b1;
    idle(40);
    check("t6_fcnt_after", 64'(frame_cnt), 64'(0));
    check_flags("t6");

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        send(W'($urandom()), 1'b0, $urandom_range(0, 1) == 1);
        idle(1);
      end
      len = $urandom_range(1, 20);
      no_eof = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++) begin
        r = W'({$urandom(), $urandom()});
        if ($urandom_range(0, 9) == 0) r = $urandom_range(0, 1) ? START : STOP;
        send(r, i == 0, (i == len - 1) && !no_eof);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    send(39'h7e, 1'b1, 1'b1);
    idle(1);
    drain();
    check_flags("rand");
    check("rand_fcnt", 64'(frame_cnt), 64'(exp_fcnt[15:0]));
    check("rand_expq_empty", 64'(expq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
